// File: rtl/tlb_translation_unit.sv
`default_nettype none
// ============================================================================
// Module   : tlb_translation_unit
// Brief    : ECO32 TLB frame memory, VA->PA translation, TBS/TBWR/TBWI/TBRI ops
//            and random-index counter. Optional macro
//            TLB_TRANSLATION_MISS_COUNTER_EN adds a saturating missCount output.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_translation_unit #(
   parameter int          ENTRIES       = 32,
   parameter int          FIXED_ENTRIES = 4,
   parameter logic [31:0] DIRECT_BASE   = 32'hC0000000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         transReq,
   output logic                         transReady,
   input  logic [31:0]                  transVirtual,
   input  logic                         transWrite,
   output logic                         transAck,
   output logic [31:0]                  transPhysical,
   output logic [1:0]                   transFault,
   input  logic                         opReq,
   input  logic [1:0]                   opCode,
   input  logic [$clog2(ENTRIES)-1:0]   opIndex,
   input  logic [19:0]                  opEntryHi,
   input  logic [21:0]                  opEntryLo,
   output logic                         opDone,
   output logic [31:0]                  opResultIndex,
   output logic [19:0]                  opResultHi,
   output logic [21:0]                  opResultLo,
   output logic [$clog2(ENTRIES)-1:0]   keyAccessIndex,
   input  logic [19:0]                  keyReadValue,
   output logic [19:0]                  keyWriteValue,
   output logic                         keyWriteEnable,
   output logic [19:0]                  keySearchKey,
   input  logic                         keyFound,
`ifdef TLB_TRANSLATION_MISS_COUNTER_EN
   input  logic [$clog2(ENTRIES)-1:0]   keyFoundIndex,
   output logic [31:0]                  missCount
`else
   input  logic [$clog2(ENTRIES)-1:0]   keyFoundIndex
`endif
);

   localparam int                 c_IDX_W    = $clog2(ENTRIES);
   localparam logic [c_IDX_W-1:0] c_RAND_MIN = c_IDX_W'(FIXED_ENTRIES);
   localparam logic [c_IDX_W-1:0] c_RAND_MAX = c_IDX_W'(ENTRIES - 1);
   localparam logic [1:0]         c_OP_TBS   = 2'd0;
   localparam logic [1:0]         c_OP_TBWR  = 2'd1;
   localparam logic [1:0]         c_OP_TBWI  = 2'd2;
   localparam logic [1:0]         c_OP_TBRI  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOOKUP  = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 w_accept;
   logic                 w_isWrite;

   logic [c_IDX_W-1:0]   r_rand;
   logic                 r_isOp;
   logic [1:0]           r_opCode;
   logic [c_IDX_W-1:0]   r_index;
   logic [19:0]          r_entryHi;
   logic [21:0]          r_entryLo;
   logic [31:0]          r_vaddr;
   logic                 r_write;

   logic [21:0]          r_frame [ENTRIES];
   logic [21:0]          w_hitEntry;
   logic [31:0]          w_transPhys;
   logic [1:0]           w_transFault;
   logic [31:0]          w_searchIndex;

   logic [31:0]          r_pendPhys;
   logic [1:0]           r_pendFault;
   logic [31:0]          r_pendIndex;
   logic [19:0]          r_pendHi;
   logic [21:0]          r_pendLo;

   logic                 r_transAck;
   logic [31:0]          r_transPhysical;
   logic [1:0]           r_transFault;
   logic                 r_opDone;
   logic [31:0]          r_opResultIndex;
   logic [19:0]          r_opResultHi;
   logic [21:0]          r_opResultLo;

   // Management ops take priority; a losing translation simply stays pending.
   assign w_accept   = (r_state == S_IDLE) && (opReq || transReq);
   assign transReady = (r_state == S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = S_LOOKUP;
         S_LOOKUP:  w_next = S_RESPOND;
         S_RESPOND: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)                    r_rand <= c_RAND_MAX;
      else if (r_rand <= c_RAND_MIN) r_rand <= c_RAND_MAX;
      else                          r_rand <= r_rand - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_isOp    <= 1'b0;
         r_opCode  <= 2'd0;
         r_index   <= '0;
         r_entryHi <= '0;
         r_entryLo <= '0;
         r_vaddr   <= '0;
         r_write   <= 1'b0;
      end else if (w_accept) begin
         r_isOp    <= opReq;
         r_opCode  <= opCode;
         r_index   <= (opReq && (opCode == c_OP_TBWR)) ? r_rand : opIndex;
         r_entryHi <= opEntryHi;
         r_entryLo <= opEntryLo;
         r_vaddr   <= transVirtual;
         r_write   <= transWrite;
      end
   end

   assign w_isWrite      = r_isOp && ((r_opCode == c_OP_TBWR) || (r_opCode == c_OP_TBWI));
   assign keySearchKey   = r_isOp ? r_entryHi : r_vaddr[31:12];
   assign keyAccessIndex = r_index;
   assign keyWriteValue  = r_entryHi;
   // Gating with reset keeps an aborted write from landing on the reset edge.
   assign keyWriteEnable = (r_state == S_LOOKUP) && w_isWrite && !reset;

   always_ff @(posedge clock) begin
      if (keyWriteEnable) r_frame[r_index] <= r_entryLo;
   end

   assign w_hitEntry    = r_frame[keyFoundIndex];
   assign w_searchIndex = keyFound ? {{(32-c_IDX_W){1'b0}}, keyFoundIndex} : 32'h80000000;

   always_comb begin
      w_transPhys  = '0;
      w_transFault = 2'd0;
      if (r_vaddr >= DIRECT_BASE)              w_transPhys  = r_vaddr & 32'h3FFFFFFF;
      else if (!keyFound)                      w_transFault = 2'd1;
      else if (!w_hitEntry[0])                 w_transFault = 2'd2;
      else if (r_write && !w_hitEntry[1])      w_transFault = 2'd3;
      else                                     w_transPhys  = {w_hitEntry[21:2], r_vaddr[11:0]};
   end

   // Results are staged in LOOKUP and published together with the strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pendPhys      <= '0;
         r_pendFault     <= '0;
         r_pendIndex     <= '0;
         r_pendHi        <= '0;
         r_pendLo        <= '0;
         r_transAck      <= 1'b0;
         r_transPhysical <= '0;
         r_transFault    <= '0;
         r_opDone        <= 1'b0;
         r_opResultIndex <= '0;
         r_opResultHi    <= '0;
         r_opResultLo    <= '0;
      end else begin
         r_transAck <= 1'b0;
         r_opDone   <= 1'b0;
         if (r_state == S_LOOKUP) begin
            if (r_isOp) begin
               if (r_opCode == c_OP_TBS) r_pendIndex <= w_searchIndex;
               if (r_opCode == c_OP_TBRI) begin
                  r_pendHi <= keyReadValue;
                  r_pendLo <= r_frame[r_index];
               end
            end else begin
               r_pendPhys  <= w_transPhys;
               r_pendFault <= w_transFault;
            end
         end
         if (r_state == S_RESPOND) begin
            if (r_isOp) begin
               r_opDone <= 1'b1;
               if (r_opCode == c_OP_TBS) r_opResultIndex <= r_pendIndex;
               if (r_opCode == c_OP_TBRI) begin
                  r_opResultHi <= r_pendHi;
                  r_opResultLo <= r_pendLo;
               end
            end else begin
               r_transAck      <= 1'b1;
               r_transPhysical <= r_pendPhys;
               r_transFault    <= r_pendFault;
            end
         end
      end
   end

   assign transAck      = r_transAck;
   assign transPhysical = r_transPhysical;
   assign transFault    = r_transFault;
   assign opDone        = r_opDone;
   assign opResultIndex = r_opResultIndex;
   assign opResultHi    = r_opResultHi;
   assign opResultLo    = r_opResultLo;

`ifdef TLB_TRANSLATION_MISS_COUNTER_EN
   logic [31:0] r_missCount;

   always_ff @(posedge clock) begin
      if (reset)
         r_missCount <= '0;
      else if ((r_state == S_RESPOND) && !r_isOp && (r_pendFault == 2'd1) &&
               (r_missCount != 32'hFFFFFFFF))
         r_missCount <= r_missCount + 32'd1;
   end

   assign missCount = r_missCount;
`endif

endmodule
`default_nettype wire

// File: doc/tlb_translation_unit.md
Name: tlb_translation_unit

Overview:
- Sits directly downstream of the TLB key memory. Drives that memory's search and access ports and consumes its found and foundIndex results.
- Owns the matching 32-entry frame memory. Translates 32-bit virtual addresses to physical addresses for the MMU.
- Executes the ECO32 TLB management ops TBS, TBWR, TBWI and TBRI, and maintains the random-index counter.

Parameters:
- ENTRIES, 32: number of TLB entries; index width is 5 bits.
- FIXED_ENTRIES, 4: lowest index the random counter can produce.
- DIRECT_BASE, 32'hC0000000: virtual addresses at or above this value are direct-mapped.

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- transReq  in  1  translation request, sampled only while transReady=1
- transReady  out  1  high in IDLE only
- transVirtual  in  32  virtual address
- transWrite  in  1  access is a store
- transAck  out  1  one-cycle result strobe
- transPhysical  out  32  physical address, valid with transAck
- transFault  out  2  0 none, 1 miss, 2 invalid, 3 write-protect
- opReq  in  1  management op request, sampled only while transReady=1
- opCode  in  2  0 TBS, 1 TBWR, 2 TBWI, 3 TBRI
- opIndex  in  5  index for TBWI and TBRI
- opEntryHi  in  20  VPN, used as write value and TBS search key
- opEntryLo  in  22  frame[21:2], W bit[1], V bit[0]
- opDone  out  1  one-cycle completion strobe
- opResultIndex  out  32  TBS result: found index zero-extended, or 32'h80000000 if not found
- opResultHi  out  20  TBRI key read value
- opResultLo  out  22  TBRI frame read value
- keyAccessIndex, keyReadValue (in, 20), keyWriteValue, keyWriteEnable, keySearchKey, keyFound (in), keyFoundIndex (in, 5): key memory interface; key memory search and read are combinational, write on clock edge.

Behaviour:
- Reset values:
  - FSM to IDLE; random counter to 31.
  - All strobes 0; all result registers 0.
  - keyWriteEnable=0.
  - Frame memory is not reset.
- FSM states: IDLE, LOOKUP, RESPOND.
  - IDLE: accept on the edge where opReq or transReq is 1. Latch all inputs, go to LOOKUP.
  - If both requests are high, opReq wins. The translation is not accepted; the requester holds it until transReady returns.
  - LOOKUP lasts 1 cycle: perform the search, read or write, and register the results. Then go to RESPOND.
  - RESPOND lasts 1 cycle: assert transAck or opDone, then go to IDLE.
- Latency and throughput: strobe is high in the cycle beginning 2 edges after the accept edge; one request per 3 cycles.
- Translation in LOOKUP, with keySearchKey = latched VPN[31:12]:
  - Direct-mapped (vaddr >= DIRECT_BASE): physical = vaddr & 32'h3FFFFFFF, fault 0, search result ignored.
  - keyFound=0: fault 1, physical 0.
  - Found entry with V=0: fault 2, physical 0.
  - Found entry with transWrite=1 and W=0: fault 3, physical 0.
  - Otherwise: physical = {frame, vaddr[11:0]}, fault 0.
  - Multiple key matches resolve to the lowest index, as returned by the key memory.
- TBS: keySearchKey = opEntryHi. Result is 32'h80000000 on miss, else {27'b0, foundIndex}.
- TBWI and TBWR: in LOOKUP, keyWriteEnable=1 for exactly 1 cycle, with keyWriteValue=opEntryHi and the frame memory written with opEntryLo at the same edge.
  - Index is opIndex for TBWI, or the random counter value sampled at the accept edge for TBWR.
- TBRI: keyAccessIndex=opIndex. Latch keyReadValue and frame[opIndex] into opResultHi and opResultLo.
- Random counter: decrements every cycle. Wraps from FIXED_ENTRIES to 31. Never leaves [FIXED_ENTRIES, 31].
- Result registers hold their values until the next completion of the same kind.
- Reset asserted mid-operation aborts the operation: no strobe, and no key or frame write on that edge.

Optional Feature:
- Macro TLB_TRANSLATION_MISS_COUNTER_EN.
- Defined: adds output missCount (32 bits), reset to 0. Increments on each transAck with fault 1, and saturates at 32'hFFFFFFFF. Direct-mapped accesses never count.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Write entry: TBWI with index 5, hi 20'h12345, lo {20'h00ABC, W=1, V=1}. Then translate 32'h12345678 with transWrite=0 -> transAck two edges after accept, physical 32'h00ABC678, fault 0.
- Protection and validity:
  - Same entry rewritten with W=0, then a store -> fault 3.
  - Entry at index 3 with V=0 -> fault 2.
  - VPN 20'h22222 absent -> fault 1, physical 0.
- Direct-mapped: virtual 32'hC0001234 -> physical 32'h00001234, fault 0, regardless of TLB contents.
- TBS:
  - Keys 20'h44444 at indices 3 and 7 -> opResultIndex 3.
  - Search 20'h99999 -> 32'h80000000.
  - TBRI index 7 -> opResultHi 20'h44444.
- Random counter and TBWR: after reset, issue TBWR on consecutive opportunities. Every write index lies in [4,31], and the counter is 31 one cycle after reset release and wraps 4 -> 31.
- Arbitration and reset: opReq and transReq high together -> op completes first and translation completes 3 cycles later. Reset asserted during LOOKUP of a TBWI -> no key write, no strobe, IDLE and transReady=1 after the reset edge.
